// File: rtl/rgb_frame_capture_if.sv
// rgb_frame_capture_if: camera byte stream in, frame buffer write port out
// master: drives capture_frame and cam_*; sees wr_en, addr_out, data_out, busy, done
// slave : the capture block, the mirror image of master
interface rgb_frame_capture_if #(parameter int ADDR_W = 13);
  logic capture_frame;
  logic cam_vsync;
  logic cam_href;
  logic cam_byte_valid;
  logic [7:0] cam_data;
  logic wr_en;
  logic [ADDR_W-1:0] addr_out;
  logic [14:0] data_out;
  logic busy;
  logic done;
  modport master(
    output capture_frame, cam_vsync, cam_href, cam_byte_valid, cam_data,
    input wr_en, addr_out, data_out, busy, done
  );
  modport slave(
    input capture_frame, cam_vsync, cam_href, cam_byte_valid, cam_data,
    output wr_en, addr_out, data_out, busy, done
  );
endinterface

// File: rtl/rgb_frame_capture.sv
// rgb_frame_capture: writes one RGB565 camera frame as RGB555 words to addresses 0..NUM_PIXELS-1
// clk, rst   : clock, asynchronous active-high reset
// bus.cam_*  : synchronised camera stream, two bytes per pixel, high byte first
// bus.wr_en/addr_out/data_out : registered buffer write, one cycle per pixel
// bus.busy/done : capture in progress, one-cycle pulse when the frame is written
module rgb_frame_capture #(
  parameter int NUM_PIXELS = 3072,
  parameter int ADDR_W = 13
) (
  input logic clk,
  input logic rst,
  rgb_frame_capture_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_VS_HI, WAIT_VS_LO, CAPTURE, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] pix_cnt, cnt_n, addr_n;
  logic phase_lo, lo_n, we_n;
  logic [7:0] hi_byte, hi_n;
  logic [14:0] data_n;
  always_comb begin
    state_n = state;
    cnt_n = pix_cnt;
    lo_n = phase_lo;
    hi_n = hi_byte;
    we_n = 1'b0;
    addr_n = bus.addr_out;
    data_n = bus.data_out;
    case (state)
      IDLE: begin
        cnt_n = '0;
        lo_n = 1'b0;
        state_n = bus.capture_frame ? WAIT_VS_HI : IDLE;
      end
      WAIT_VS_HI: state_n = bus.cam_vsync ? WAIT_VS_LO : WAIT_VS_HI;
      WAIT_VS_LO: state_n = bus.cam_vsync ? WAIT_VS_LO : CAPTURE;
      CAPTURE: begin
        if (bus.cam_vsync) begin
          // short frame: rearm for the next frame from address 0
          cnt_n = '0;
          lo_n = 1'b0;
          state_n = WAIT_VS_LO;
        end else if (!bus.cam_href) begin
          lo_n = 1'b0;
        end else if (bus.cam_byte_valid) begin
          if (!phase_lo) begin
            hi_n = bus.cam_data;
            lo_n = 1'b1;
          end else begin
            // G keeps its five MSBs; lo[5] is the dropped G LSB
            we_n = 1'b1;
            addr_n = pix_cnt;
            data_n = {hi_byte, bus.cam_data[7:6], bus.cam_data[4:0]};
            cnt_n = pix_cnt + 1'b1;
            lo_n = 1'b0;
            state_n = pix_cnt == LAST ? DONE : CAPTURE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix_cnt <= '0;
      phase_lo <= 1'b0;
      hi_byte <= '0;
      bus.wr_en <= 1'b0;
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      pix_cnt <= cnt_n;
      phase_lo <= lo_n;
      hi_byte <= hi_n;
      bus.wr_en <= we_n;
      bus.addr_out <= addr_n;
      bus.data_out <= data_n;
      bus.busy <= state_n != IDLE;
      bus.done <= state == DONE;
    end
  end
endmodule

// File: tb/tb_rgb_frame_capture.sv
// tb_rgb_frame_capture: randomized camera frames checked against a pixel-list reference model
module tb_rgb_frame_capture;
  typedef struct packed {logic [12:0] a; logic [14:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n, done_cyc, last_wr, fall_cyc;
  logic busy_q = 1'b0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [14:0] sent_q[$];
  logic [15:0] pre_q[$];
  rgb_frame_capture_if #(.ADDR_W(13)) bus();
  rgb_frame_capture #(.NUM_PIXELS(3072), .ADDR_W(13)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      got_q.push_back(wr_t'{a: bus.addr_out, d: bus.data_out});
      last_wr = cyc;
    end
    if (bus.done === 1'b1) begin
      done_n = done_n + 1;
      done_cyc = cyc;
    end
    if (busy_q === 1'b1 && bus.busy === 1'b0) fall_cyc = cyc;
    busy_q = bus.busy;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    got_q.delete();
    exp_q.delete();
    sent_q.delete();
    done_n = 0;
    done_cyc = -1;
    last_wr = -1;
    fall_cyc = -1;
  endtask
  task automatic start_capture();
    bus.capture_frame = 1'b1;
    step();
    bus.capture_frame = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bus.cam_byte_valid = 1'b1;
    bus.cam_data = b;
    step();
    bus.cam_byte_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
  endtask
  task automatic cam_frame(input int lines, input int ppl, input int stop_at,
                           input int odd_line, input bit gaps, input int cap_at);
    int n;
    logic [15:0] p;
    n = 0;
    bus.cam_vsync = 1'b1;
    repeat (3) step();
    bus.cam_vsync = 1'b0;
    repeat (2) step();
    for (int l = 0; l < lines; l++) begin
      bus.cam_href = 1'b1;
      for (int k = 0; k < ppl; k++) begin
        if (n == stop_at) begin
          bus.cam_href = 1'b0;
          return;
        end
        p = pre_q.size() != 0 ? pre_q.pop_front() : 16'($urandom);
        if (n == cap_at) bus.capture_frame = 1'b1;
        send_byte(p[15:8], gaps);
        bus.capture_frame = 1'b0;
        send_byte(p[7:0], gaps);
        sent_q.push_back({p[15:11], p[10:6], p[4:0]});
        n++;
      end
      if (l == odd_line) send_byte(8'($urandom), gaps);
      bus.cam_href = 1'b0;
      repeat (2) step();
    end
    bus.cam_vsync = 1'b1;
    repeat (4) step();
  endtask
  task automatic build_exp(input int count, input int from);
    for (int i = 0; i < count; i++) exp_q.push_back(wr_t'{a: 13'(i), d: sent_q[from + i]});
  endtask
  function automatic int first_bad();
    int n;
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return got_q.size() != exp_q.size() ? n : -1;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.wr_en, bus.addr_out, bus.data_out, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got wr=%b addr=%0d data=%h busy=%b done=%b, required all 0",
               bus.wr_en, bus.addr_out, bus.data_out, bus.busy, bus.done);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_conversion();
    clear();
    pre_q = '{16'hF81F, 16'h07E0, 16'hFFFF};
    start_capture();
    cam_frame(1, 3, -1, -1, 1'b0, -1);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== wr_t'{a: 13'd0, d: 15'h7C1F}) begin
      errors++;
      $display("FAIL conv_px0: got n=%0d %h, required n=3 addr 0 data 7C1F", got_q.size(), got_q[0]);
    end
    checks++;
    if (got_q[1] !== wr_t'{a: 13'd1, d: 15'h03E0}) begin
      errors++;
      $display("FAIL conv_px1: got addr %0d data %h, required addr 1 data 03E0", got_q[1].a, got_q[1].d);
    end
    checks++;
    if (got_q[2] !== wr_t'{a: 13'd2, d: 15'h7FFF}) begin
      errors++;
      $display("FAIL conv_px2: got addr %0d data %h, required addr 2 data 7FFF", got_q[2].a, got_q[2].d);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_full_frame();
    int bad;
    clear();
    start_capture();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b, required 1", bus.busy);
    end
    cam_frame(64, 48, -1, -1, 1'b0, -1);
    build_exp(3072, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL full_writes: idx %0d of %0d writes got %h, required %0d writes %h",
               bad, got_q.size(), got_q[bad], exp_q.size(), exp_q[bad]);
    end
    checks++;
    if (done_n != 1 || done_cyc != last_wr + 1) begin
      errors++;
      $display("FAIL full_done: got %0d pulses at cycle %0d, required 1 at %0d", done_n, done_cyc, last_wr + 1);
    end
    checks++;
    if (fall_cyc != done_cyc || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got fall cycle %0d busy %b, required %0d and 0", fall_cyc, bus.busy, done_cyc);
    end
  endtask
  task automatic test_reset_mid_frame();
    int bad;
    clear();
    start_capture();
    cam_frame(64, 48, 101, -1, 1'b0, -1);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.addr_out !== 13'd100) begin
      errors++;
      $display("FAIL pre_reset_write: got wr=%b addr=%0d, required 1 and 100", bus.wr_en, bus.addr_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wr_en, bus.addr_out, bus.data_out, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got wr=%b addr=%0d data=%h busy=%b done=%b, required all 0",
               bus.wr_en, bus.addr_out, bus.data_out, bus.busy, bus.done);
    end
    step();
    rst = 1'b0;
    got_q.delete();
    cam_frame(3, 48, -1, -1, 1'b0, -1);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d writes, required 0", got_q.size());
    end
    clear();
    start_capture();
    cam_frame(64, 48, -1, -1, 1'b0, -1);
    build_exp(3072, 0);
    bad = first_bad();
    checks++;
    if (bad != -1 || done_n != 1) begin
      errors++;
      $display("FAIL reset_refill: idx %0d of %0d writes got %h required %h, done %0d required 1",
               bad, got_q.size(), got_q[bad], exp_q[bad], done_n);
    end
  endtask
  task automatic test_odd_byte();
    int bad;
    clear();
    start_capture();
    cam_frame(64, 48, -1, 3, 1'b1, -1);
    build_exp(3072, 0);
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL odd_writes: idx %0d of %0d writes got %h, required %0d writes %h",
               bad, got_q.size(), got_q[bad], exp_q.size(), exp_q[bad]);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL odd_done: got %0d pulses, required 1", done_n);
    end
  endtask
  task automatic test_short_frame();
    int bad;
    clear();
    start_capture();
    cam_frame(64, 48, 1000, -1, 1'b0, -1);
    bus.cam_vsync = 1'b1;
    repeat (3) step();
    checks++;
    if (done_n != 0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL short_no_done: got %0d pulses busy %b, required 0 and 1", done_n, bus.busy);
    end
    cam_frame(64, 48, -1, -1, 1'b0, -1);
    build_exp(1000, 0);
    build_exp(3072, 1000);
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL short_writes: idx %0d of %0d writes got %h, required %0d writes %h",
               bad, got_q.size(), got_q[bad], exp_q.size(), exp_q[bad]);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL short_done: got %0d pulses, required 1", done_n);
    end
  endtask
  task automatic test_ignored();
    int bad;
    clear();
    start_capture();
    cam_frame(65, 48, -1, -1, 1'b0, 500);
    build_exp(3072, 0);
    bad = first_bad();
    checks++;
    if (bad != -1 || done_n != 1) begin
      errors++;
      $display("FAIL ignored_writes: idx %0d of %0d writes got %h required %h, done %0d required 1",
               bad, got_q.size(), got_q[bad], exp_q[bad], done_n);
    end
    clear();
    cam_frame(4, 48, -1, -1, 1'b1, -1);
    checks++;
    if (got_q.size() != 0 || done_n != 0) begin
      errors++;
      $display("FAIL no_capture: got %0d writes %0d done, required 0 and 0", got_q.size(), done_n);
    end
  endtask
  initial begin
    bus.capture_frame = 1'b0;
    bus.cam_vsync = 1'b1;
    bus.cam_href = 1'b0;
    bus.cam_byte_valid = 1'b0;
    bus.cam_data = '0;
    clear();
    test_reset();
    test_conversion();
    test_full_frame();
    test_reset_mid_frame();
    test_odd_byte();
    test_short_frame();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
